// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared constants and state encoding for the SSP receive path
// Contents: default word length, receive FSM state encoding, counter-width helper.
package ssp_pkg;

   localparam int SSP_DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } ssp_rx_state_e;

   // Counter must be able to hold the value DATA_W itself.
   function automatic int ssp_cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/ssp_rx_shift.sv
// rtl/ssp_rx_shift.sv - serial-in shift register with saturating bit counter
// Ports:
//   i_clk, i_reset_bar : clock, asynchronous active-low reset
//   i_clr              : clear shift register and count (wins over i_shift_en)
//   i_shift_en         : shift i_bit into the LSB and count one sample
//   i_bit              : serial data bit
//   o_word             : current shift register contents
//   o_count_done       : DATA_W samples have been collected
module ssp_rx_shift
   import ssp_pkg::*;
#(
   parameter int DATA_W = SSP_DATA_W_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_reset_bar,
   input  logic              i_clr,
   input  logic              i_shift_en,
   input  logic              i_bit,
   output logic [DATA_W-1:0] o_word,
   output logic              o_count_done
);

   localparam int               CNT_W   = ssp_cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

   logic [DATA_W-1:0] sreg_d, sreg_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (i_clr) begin
         sreg_d = '0;
         cnt_d  = '0;
      end else if (i_shift_en && (cnt_q != CNT_MAX)) begin
         // Saturate at DATA_W so a stray enable can never wrap the count.
         sreg_d = {sreg_q[DATA_W-2:0], i_bit};
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_bar) begin
      if (!i_reset_bar) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_word       = sreg_q;
   assign o_count_done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ssp_rx_ctrl.sv
// rtl/ssp_rx_ctrl.sv - SSP serial receive controller with one-word holding register
// Ports:
//   i_clk, i_reset_bar : clock, asynchronous active-low reset
//   i_enable           : receive enable; low aborts a frame in progress
//   i_sample_tick      : one-cycle bit sample strobe
//   i_rx_fss, i_rx_data: pre-synchronized frame sync and serial data
//   o_rx_word, o_rx_valid, i_rx_ack : holding register and its handshake
//   o_overrun, o_frame_err, i_clr_err : sticky error flags and their clear
//   o_busy             : FSM not idle
module ssp_rx_ctrl
   import ssp_pkg::*;
#(
   parameter int DATA_W = SSP_DATA_W_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_reset_bar,
   input  logic              i_enable,
   input  logic              i_sample_tick,
   input  logic              i_rx_fss,
   input  logic              i_rx_data,
   output logic [DATA_W-1:0] o_rx_word,
   output logic              o_rx_valid,
   input  logic              i_rx_ack,
   output logic              o_overrun,
   output logic              o_frame_err,
   input  logic              i_clr_err,
   output logic              o_busy
);

   ssp_rx_state_e     state_d, state_q;
   logic [DATA_W-1:0] shift_word;
   logic              count_done;
   logic              shift_clr, shift_en, fe_set, done;
   logic              load, ovr_set;
   logic [DATA_W-1:0] rx_word_d, rx_word_q;
   logic              rx_valid_d, rx_valid_q;
   logic              overrun_d, overrun_q;
   logic              frame_err_d, frame_err_q;

   ssp_rx_shift #(.DATA_W(DATA_W)) u_shift (
      .i_clk        (i_clk),
      .i_reset_bar  (i_reset_bar),
      .i_clr        (shift_clr),
      .i_shift_en   (shift_en),
      .i_bit        (i_rx_data),
      .o_word       (shift_word),
      .o_count_done (count_done)
   );

   // FSM state register
   always_ff @(posedge i_clk or negedge i_reset_bar) begin
      if (!i_reset_bar) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   // FSM next state. A full word waits one cycle in SHIFT (count_done seen)
   // before DONE, which places the holding-register load two edges after
   // the edge that captured the last bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_enable && i_sample_tick && i_rx_fss) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (!i_enable)      state_d = ST_IDLE;
            else if (count_done) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      shift_clr = 1'b0;
      shift_en  = 1'b0;
      fe_set    = 1'b0;
      done      = 1'b0;
      o_busy    = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            shift_clr = i_enable && i_sample_tick && i_rx_fss;
         end
         ST_SHIFT: begin
            if (!i_enable) begin
               shift_clr = 1'b1;
            end else if (!count_done && i_sample_tick) begin
               // Sync mid-word restarts the word; the sync tick is not data.
               if (i_rx_fss) begin
                  fe_set    = 1'b1;
                  shift_clr = 1'b1;
               end else begin
                  shift_en  = 1'b1;
               end
            end
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Holding register and sticky flags; a new error beats a same-cycle clear.
   always_comb begin
      load        = done && (!rx_valid_q || i_rx_ack);
      ovr_set     = done && !load;
      rx_word_d   = load ? shift_word : rx_word_q;
      rx_valid_d  = load ? 1'b1 : (i_rx_ack ? 1'b0 : rx_valid_q);
      overrun_d   = ovr_set || (overrun_q && !i_clr_err);
      frame_err_d = fe_set || (frame_err_q && !i_clr_err);
   end

   always_ff @(posedge i_clk or negedge i_reset_bar) begin
      if (!i_reset_bar) begin
         rx_word_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_word_q   <= rx_word_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_rx_word   = rx_word_q;
   assign o_rx_valid  = rx_valid_q;
   assign o_overrun   = overrun_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// tb/tb_ssp_rx_ctrl.sv - self-checking bench for ssp_rx_ctrl
module tb_ssp_rx_ctrl;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          tick = 1'b0;
   logic          fss = 1'b0;
   logic          rxd = 1'b0;
   logic          ack = 1'b0;
   logic          clr = 1'b0;
   logic [DW-1:0] word;
   logic          valid, ovr, fe, busy;

   always #5 clk = ~clk;

   ssp_rx_ctrl #(.DATA_W(DW)) dut (
      .i_clk         (clk),
      .i_reset_bar   (rst_n),
      .i_enable      (en),
      .i_sample_tick (tick),
      .i_rx_fss      (fss),
      .i_rx_data     (rxd),
      .o_rx_word     (word),
      .o_rx_valid    (valid),
      .i_rx_ack      (ack),
      .o_overrun     (ovr),
      .o_frame_err   (fe),
      .i_clr_err     (clr),
      .o_busy        (busy)
   );

   int            n_checks = 0;
   int            n_errors = 0;

   // Reference model: what the consumer should currently see.
   logic [DW-1:0] exp_word  = '0;
   logic          exp_valid = 1'b0;
   logic          exp_ovr   = 1'b0;
   logic          exp_fe    = 1'b0;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_word"},  16'(word),  16'(exp_word));
      check_eq({tag, "_valid"}, 16'(valid), 16'(exp_valid));
      check_eq({tag, "_ovr"},   16'(ovr),   16'(exp_ovr));
      check_eq({tag, "_fe"},    16'(fe),    16'(exp_fe));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles carry random line noise; without a tick it must be ignored.
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         fss = 1'($urandom);
         rxd = 1'($urandom);
         step();
      end
      fss = 1'b0;
   endtask

   task automatic do_tick(input logic f, input logic d);
      tick = 1'b1;
      fss  = f;
      rxd  = d;
      step();
      tick = 1'b0;
      fss  = 1'b0;
      rxd  = 1'($urandom);
   endtask

   // One frame: sync, optional n_pre bits cut short by a mid-word sync,
   // then a full word MSB first. ack_done / clr_e apply in the DONE cycle;
   // clr_e is also raised during the mid-word sync tick.
   task automatic send_word(input logic [DW-1:0] w, input logic ack_done,
                            input int n_pre, input logic clr_e);
      logic ovr_ev;
      gap($urandom_range(0, 2));
      do_tick(1'b1, 1'($urandom));
      if (n_pre > 0) begin
         for (int i = 0; i < n_pre; i++) begin
            gap($urandom_range(0, 2));
            do_tick(1'b0, 1'($urandom));
         end
         gap($urandom_range(0, 2));
         clr = clr_e;
         do_tick(1'b1, 1'b0);
         clr = 1'b0;
         if (clr_e) exp_ovr = 1'b0;
         exp_fe = 1'b1;
         check_eq("fe_mid", 16'(fe), 16'(1));
      end
      for (int i = DW - 1; i >= 0; i--) begin
         gap($urandom_range(0, 2));
         do_tick(1'b0, w[i]);
      end
      check_eq("busy_last", 16'(busy), 16'(1));
      check_eq("valid_lat1", 16'(valid), 16'(exp_valid));
      step();
      check_eq("valid_lat2", 16'(valid), 16'(exp_valid));
      check_eq("busy_done", 16'(busy), 16'(1));
      ack = ack_done;
      clr = clr_e;
      step();
      ack = 1'b0;
      clr = 1'b0;
      ovr_ev = exp_valid && !ack_done;
      if (!ovr_ev) begin
         exp_word  = w;
         exp_valid = 1'b1;
      end
      if (clr_e) begin
         exp_ovr = 1'b0;
         exp_fe  = 1'b0;
      end
      if (ovr_ev) exp_ovr = 1'b1;
      check_outputs("frame");
      check_eq("busy_end", 16'(busy), 16'(0));
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      step();
      ack = 1'b0;
      exp_valid = 1'b0;
      check_eq("ack_valid", 16'(valid), 16'(0));
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      step();
      clr = 1'b0;
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
      check_eq("clr_ovr", 16'(ovr), 16'(0));
      check_eq("clr_fe",  16'(fe),  16'(0));
   endtask

   initial begin
      // Reset state
      #12;
      check_outputs("reset");
      check_eq("reset_busy", 16'(busy), 16'(0));
      rst_n = 1'b1;
      #5;
      step();
      en = 1'b1;

      // Basic frame A5 with latency checks
      send_word(8'hA5, 1'b0, 0, 1'b0);
      check_eq("a5_word", 16'(word), 16'h00A5);
      ack_pulse();
      ack_pulse();   // ack while empty is ignored

      // Overrun: 3C held, C3 lost, clear
      send_word(8'h3C, 1'b0, 0, 1'b0);
      send_word(8'hC3, 1'b0, 0, 1'b0);
      check_eq("ovr_word", 16'(word), 16'h003C);
      check_eq("ovr_flag", 16'(ovr), 16'(1));
      clr_pulse();

      // Ack in the DONE cycle replaces the held word
      send_word(8'hC3, 1'b1, 0, 1'b0);
      check_eq("ackdone_word", 16'(word), 16'h00C3);
      check_eq("ackdone_ovr", 16'(ovr), 16'(0));

      // Mid-word sync after 3 bits, then a full word
      ack_pulse();
      send_word(8'h81, 1'b0, 3, 1'b0);
      check_eq("fe_word", 16'(word), 16'h0081);
      check_eq("fe_flag", 16'(fe), 16'(1));
      clr_pulse();

      // Enable dropped during bit 4
      do_tick(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) do_tick(1'b0, 1'($urandom));
      en = 1'b0;
      do_tick(1'b0, 1'b1);
      check_eq("en_busy", 16'(busy), 16'(0));
      check_outputs("en_drop");
      gap(2);
      en = 1'b1;
      check_outputs("en_after");

      // Asynchronous reset between edges during bit 5
      do_tick(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) do_tick(1'b0, 1'($urandom));
      tick = 1'b1;
      rxd  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      exp_word = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_fe = 1'b0;
      check_outputs("async_rst");
      check_eq("async_rst_busy", 16'(busy), 16'(0));
      step();
      tick = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1);
      check_eq("post_rst_busy", 16'(busy), 16'(0));
      check_outputs("post_rst");
      send_word(8'h7E, 1'b0, 0, 1'b0);
      check_eq("rst_7e", 16'(word), 16'h007E);

      // Error wins over a same-cycle clear
      send_word(8'h55, 1'b0, 2, 1'b1);
      check_eq("errwins_ovr", 16'(ovr), 16'(1));

      // Randomized traffic against the model
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 2) == 0) ack_pulse();
         if ($urandom_range(0, 4) == 0) clr_pulse();
         send_word(8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                   ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
